// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the icache refill path
// and the data path, with a per-transaction watchdog and statistics counters.
module unified_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_instr,
  output logic        err_timeout,
  output logic [31:0] i_grant_count,
  output logic [31:0] d_grant_count,
  output logic [31:0] conflict_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_d;
  logic        r_err;
  logic [31:0] r_wdog;
  logic [31:0] r_i_cnt;
  logic [31:0] r_d_cnt;
  logic [31:0] r_conf_cnt;
  logic        w_in_gnt;
  logic        w_gnt_valid;
  logic        w_done;
  logic        w_abort;
  logic        w_expire;

  // Status of the currently granted transaction.
  always_comb begin
    w_in_gnt    = (r_state == ST_GNT_I) || (r_state == ST_GNT_D);
    if (r_state == ST_GNT_I) begin
      w_gnt_valid = i_valid;
    end else if (r_state == ST_GNT_D) begin
      w_gnt_valid = d_valid;
    end else begin
      w_gnt_valid = 1'b0;
    end
    w_done   = w_in_gnt && w_gnt_valid && mem_ready;
    w_abort  = w_in_gnt && !w_gnt_valid;
    // mem_ready on the expiry cycle wins over the watchdog.
    w_expire = (TIMEOUT_CYCLES != 32'd0) && w_in_gnt && w_gnt_valid && !mem_ready &&
               (r_wdog == TIMEOUT_CYCLES - 32'd1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: round-robin on ties, every grant ends back in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_valid && d_valid) begin
          w_next = r_last_d ? ST_GNT_I : ST_GNT_D;
        end else if (i_valid) begin
          w_next = ST_GNT_I;
        end else if (d_valid) begin
          w_next = ST_GNT_D;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        if (w_done || w_abort || w_expire) begin
          w_next = ST_IDLE;
        end else begin
          w_next = r_state;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Fairness pointer, watchdog, sticky error flag and statistics.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_last_d   <= 1'b1;
      r_err      <= 1'b0;
      r_wdog     <= 32'd0;
      r_i_cnt    <= 32'd0;
      r_d_cnt    <= 32'd0;
      r_conf_cnt <= 32'd0;
    end else begin
      if (w_done || w_expire) begin
        r_last_d <= (r_state == ST_GNT_D);
      end
      if (!w_in_gnt) begin
        r_wdog <= 32'd0;
      end else if (!mem_ready) begin
        r_wdog <= r_wdog + 32'd1;
      end
      if (w_expire) begin
        r_err <= 1'b1;
      end
      if (w_done && (r_state == ST_GNT_I)) begin
        r_i_cnt <= r_i_cnt + 32'd1;
      end
      if (w_done && (r_state == ST_GNT_D)) begin
        r_d_cnt <= r_d_cnt + 32'd1;
      end
      if (i_valid && d_valid && !(w_done || w_expire)) begin
        r_conf_cnt <= r_conf_cnt + 32'd1;
      end
    end
  end

  // Output decode; everything is held at zero while reset is asserted.
  always_comb begin
    i_ready        = 1'b0;
    i_rdata        = 32'd0;
    d_ready        = 1'b0;
    d_rdata        = 32'd0;
    mem_valid      = 1'b0;
    mem_addr       = 32'd0;
    mem_wdata      = 32'd0;
    mem_wstrb      = 4'd0;
    mem_instr      = 1'b0;
    err_timeout    = 1'b0;
    i_grant_count  = 32'd0;
    d_grant_count  = 32'd0;
    conflict_count = 32'd0;
    if (resetn) begin
      err_timeout    = r_err;
      i_grant_count  = r_i_cnt;
      d_grant_count  = r_d_cnt;
      conflict_count = r_conf_cnt;
      case (r_state)
        ST_GNT_I: begin
          mem_valid = i_valid && !w_expire;
          mem_addr  = i_addr;
          mem_instr = 1'b1;
          i_ready   = w_done || w_expire;
          i_rdata   = w_done ? mem_rdata : (w_expire ? ERR_RDATA : 32'd0);
        end
        ST_GNT_D: begin
          mem_valid = d_valid && !w_expire;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          mem_wstrb = d_wstrb;
          d_ready   = w_done || w_expire;
          d_rdata   = w_done ? mem_rdata : (w_expire ? ERR_RDATA : 32'd0);
        end
        default: begin
          mem_valid = 1'b0;
        end
      endcase
    end else begin
      mem_valid = 1'b0;
    end
  end

endmodule
